// File: rtl/adc_fifo_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_fifo_framer_pkg
// Purpose : Shared constants, FSM state encoding and the header-assembly
//           helper for the ADC-to-FIFO burst framer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package adc_fifo_framer_pkg;

  // Magic nibble in the top four bits of every burst header word.
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // Framer FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // Builds a header word up to 64 bits wide: magic nibble at the top of a
  // dw-bit word, the sequence number in the low sw bits, zeros between.
  // Callers cast the result down to their own word width.
  function automatic logic [63:0] build_header(input logic [31:0] seq,
                                               input int          dw,
                                               input int          sw);
    logic [63:0] h;
    h = 64'(seq) & ((64'd1 << sw) - 64'd1);
    h = h | (64'(HDR_MAGIC) << (dw - 4));
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_fifo_framer_if.sv
`default_nettype none
// ============================================================================
// Module  : adc_fifo_framer_if
// Purpose : FIFO write-side bus between the framer and the async FIFO.
// Ports   : wr_en   - write strobe (framer -> FIFO)
//           wr_data - write word    (framer -> FIFO)
//           full    - FIFO full     (FIFO -> framer)
// Revision: 1.0 - initial release
// ============================================================================
interface adc_fifo_framer_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;

  modport master (output wr_en, output wr_data, input full);
  modport slave  (input wr_en, input wr_data, output full);

endinterface
`default_nettype wire

// File: rtl/framer_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : framer_skid_buf
// Purpose : 2-entry in-order staging buffer between the sample input and the
//           FIFO write port. A push with both entries held and no pop in the
//           same cycle is refused and reported on drop_o.
// Ports   : wr_clk, wr_rst_n   - clock, asynchronous active-high reset
//           flush_i            - discard all entries (wins over push/pop)
//           push_i/push_data_i - enqueue request and data
//           pop_i              - dequeue request (ignored when empty)
//           count_o            - entries held (0..2)
//           head_o             - oldest entry
//           drop_o             - push refused this cycle
// Revision: 1.0 - initial release
// ============================================================================
module framer_skid_buf
  import adc_fifo_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  drop_o
);

  logic [DATA_WIDTH-1:0] ent0_q;
  logic [DATA_WIDTH-1:0] ent1_q;
  logic [1:0]            count_q;
  logic                  pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  // A same-cycle pop frees a slot, so only a push against a full buffer
  // with no pop is refused.
  assign drop_o  = push_i && !pop_ok && (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = ent0_q;

  always_ff @(posedge wr_clk or posedge wr_rst_n) begin
    if (wr_rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_q  <= push_data_i;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            ent1_q  <= push_data_i;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new sample lands behind the survivor.
          if (count_q == 2'd1) begin
            ent0_q <= push_data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_fifo_framer.sv
`default_nettype none
// ============================================================================
// Module  : adc_fifo_framer
// Purpose : Write-side producer for the async FIFO. Frames ADC samples into
//           bursts of one header word plus BURST_LEN sample words. Samples
//           that cannot be staged while the FIFO is full are dropped,
//           counted and flagged; a burst never contains a gap.
// Ports   : wr_clk, wr_rst_n - clock, asynchronous active-high reset
//           enable           - start/continue framing (level)
//           smp_valid/data   - sample strobe and value, no backpressure
//           fifo             - FIFO write bus (wr_en, wr_data, full)
//           seq_num          - sequence number of current/next header
//           drop_count       - dropped samples, saturating
//           overflow         - sticky drop flag
//           clear_ovf        - clears overflow and drop_count
//           busy             - framer not idle
// Revision: 1.0 - initial release
// ============================================================================
module adc_fifo_framer
  import adc_fifo_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,  // must be >= SEQ_WIDTH + 4
  parameter int BURST_LEN  = 8,   // must be >= 2
  parameter int SEQ_WIDTH  = 8,   // at most 32
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  enable,
  input  logic                  smp_valid,
  input  logic [DATA_WIDTH-1:0] smp_data,
  adc_fifo_framer_if.master     fifo,
  output logic [SEQ_WIDTH-1:0]  seq_num,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic                  busy
);

  localparam int                    CW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0]         LAST_IDX = CW'(BURST_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] HDR_RST  =
      DATA_WIDTH'(build_header(32'd0, DATA_WIDTH, SEQ_WIDTH));

  state_t                state_q, state_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  drop;
  logic                  burst_end;
  logic                  wr_en_w;
  logic [1:0]            stg_count;
  logic [DATA_WIDTH-1:0] stg_head;

  framer_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stage (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (smp_data),
    .pop_i       (pop),
    .count_o     (stg_count),
    .head_o      (stg_head),
    .drop_o      (drop)
  );

  // Once a burst has started, samples are taken regardless of enable so the
  // burst can complete.
  assign push = smp_valid && (enable || (state_q != ST_IDLE));

  always_comb begin
    wr_en_w = 1'b0;
    case (state_q)
      ST_HDR:  wr_en_w = !fifo.full;
      ST_DATA: wr_en_w = (stg_count != 2'd0) && !fifo.full;
      default: wr_en_w = 1'b0;
    endcase
  end

  assign pop       = (state_q == ST_DATA) && wr_en_w;
  assign burst_end = pop && (burst_cnt_q == LAST_IDX);
  // Leftover samples are discarded only when the framer goes back to idle;
  // back-to-back bursts keep them for the next burst.
  assign flush     = burst_end && !enable;

  assign fifo.wr_en   = wr_en_w;
  assign fifo.wr_data = (state_q == ST_HDR) ? hdr_q : stg_head;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    seq_d       = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (wr_en_w) begin
          state_d     = ST_DATA;
          burst_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (pop) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
          if (burst_end) begin
            burst_cnt_d = '0;
            seq_d       = seq_q + SEQ_WIDTH'(1);
            state_d     = enable ? ST_HDR : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Header word is registered so wr_data always comes straight from a flop;
  // it tracks the sequence number one step ahead.
  assign hdr_d = DATA_WIDTH'(build_header(32'(seq_d), DATA_WIDTH, SEQ_WIDTH));

  // A drop in the same cycle as clear_ovf takes priority and leaves the
  // counter at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clear_ovf) begin
        drop_cnt_d = CNT_WIDTH'(1);
      end else if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end else if (clear_ovf) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst_n) begin
    if (wr_rst_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      seq_q       <= '0;
      hdr_q       <= HDR_RST;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      seq_q       <= seq_d;
      hdr_q       <= hdr_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign seq_num    = seq_q;
  assign drop_count = drop_cnt_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/adc_fifo_framer.md
Name: adc_fifo_framer

Overview:
Write-side producer for the async FIFO in the wr_clk domain. Takes one ADC sample per cycle at most, with no backpressure, and frames the samples into fixed-length bursts. Each burst is one header word followed by BURST_LEN sample words, written through the FIFO's wr_en/wr_data/full interface. Samples that cannot be buffered while the FIFO is full are dropped, counted and flagged; a burst never contains a gap.

Parameters:
DATA_WIDTH, 16, FIFO word / sample width; must be >= SEQ_WIDTH+4.
BURST_LEN, 8, sample words per burst; must be >= 2.
SEQ_WIDTH, 8, burst sequence-number width (wraps modulo 2^SEQ_WIDTH).
CNT_WIDTH, 16, drop counter width (saturating).

Ports:
wr_clk  in  1  write-domain clock
wr_rst_n  in  1  reset, asynchronous, active-high
enable  in  1  level; start/continue framing
smp_valid  in  1  sample strobe, max one per cycle
smp_data  in  DATA_WIDTH  sample value
wr_en  out  1  FIFO write strobe
wr_data  out  DATA_WIDTH  FIFO write word
full  in  1  FIFO full flag
seq_num  out  SEQ_WIDTH  sequence number of current/next header
drop_count  out  CNT_WIDTH  dropped samples, saturates at all-ones
overflow  out  1  sticky, set on any drop
clear_ovf  in  1  single-cycle pulse; clears overflow and drop_count
busy  out  1  state != IDLE

Behaviour:
- Reset (wr_rst_n=1, asynchronous): state IDLE, staging buffer emptied, burst count 0, seq_num 0, drop_count 0, overflow 0. wr_en is 0 while in reset and in IDLE.
- Staging: 2-entry in-order buffer.
  - Push when smp_valid and (enable or state != IDLE).
  - Pop on every DATA-state write.
  - Push with 2 entries held and no pop in the same cycle: the sample is dropped, drop_count increments (saturating), overflow is set.
  - Push and pop in the same cycle when 2 entries are held: accepted.
- smp_valid while IDLE and enable=0: ignored; no drop is counted.
- wr_data is driven only from registers (the header register or the staging head). wr_en is combinational from state, staging-valid and full; wr_en is never 1 while full=1.
- Minimum sample-to-write latency is 1 cycle.
- FSM:
  - IDLE: on enable=1, go to HDR on the next cycle.
  - HDR: wr_data = header. Header format: bits [DATA_WIDTH-1:DATA_WIDTH-4] = 4'hA, bits [SEQ_WIDTH-1:0] = seq_num, all other bits 0. wr_en = !full. On the write, go to DATA with burst count = 0. If full, stall in HDR; samples arriving meanwhile go to staging.
  - DATA: wr_en = staging non-empty && !full, wr_data = staging head. Each write increments the burst count. The write with count == BURST_LEN-1 ends the burst: seq_num increments (wraps), and the next state is HDR if enable=1, else IDLE.
- enable deasserted mid-burst: the burst completes; samples keep being accepted until BURST_LEN samples have been written, then the FSM goes to IDLE. Staging is flushed on entry to IDLE.
- Header is emitted eagerly at burst start, without waiting for the first sample.
- Sustained lossless input rate is BURST_LEN/(BURST_LEN+1) samples per cycle; above that rate, staging fills and samples drop.
- clear_ovf together with a drop in the same cycle: the drop wins; overflow=1, drop_count=1.
- full toggling mid-burst only stalls writes; burst word order and length are preserved.

Decomposition:
- Package adc_fifo_framer_pkg: HDR_MAGIC (4'hA), state enum (IDLE, HDR, DATA), header-assembly function.
- Sub-module framer_skid_buf: the 2-entry staging buffer, with push/pop/count/head ports and a drop output.

Test Plan:
- Reset, enable=1, full=0, 8 samples 0..7 at one every 2 cycles -> FIFO receives 0xA000, then 0..7, then header 0xA001 is emitted; drop_count=0.
- Continuous smp_valid every cycle for 64 cycles, full=0 -> each burst is a header plus 8 words in order; drops occur only after staging saturates; written count + drop_count = 64.
- full=1 held for 5 cycles during DATA while samples arrive every cycle -> 2 samples are buffered and 3 dropped; drop_count=3, overflow=1; the remaining sequence has no gaps and each burst has exactly 8 words.
- enable dropped after the 3rd sample of a burst -> 5 more samples are written, then IDLE and busy=0; later samples are ignored and not counted.
- clear_ovf pulsed in the same cycle as a drop -> overflow=1, drop_count=1; next clear_ovf with no drop -> 0/0.
- Run 257 bursts -> seq_num wraps, so the 257th header is 0xA000; wr_rst_n pulsed mid-burst -> wr_en drops immediately and the next header is 0xA000.
